// File: rtl/spi_rx_pingpong_writer.sv
`default_nettype none
// ============================================================================
// Module   : spi_rx_pingpong_writer
// Brief    : Oversampled SPI mode-0 slave receiver that fills a two-bank
//            ping-pong RAM and hands full banks to the DSP stage.
// Revision : 1.0 - initial release
// ============================================================================
module spi_rx_pingpong_writer #(
    parameter int DATADEPTH = 128,
    parameter int AW        = 7
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          spi_sclk,
    input  logic          spi_cs_n,
    input  logic          spi_mosi,
    output logic          wr_en,
    output logic          wr_bank,
    output logic [AW-1:0] wr_addr,
    output logic [7:0]    wr_data,
    output logic          ready,
    output logic          rd_bank,
    input  logic          finish,
    output logic          overflow,
    output logic          frame_err
);

    typedef enum logic [0:0] {
        ST_FILL = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    localparam logic [AW-1:0] c_LAST_ADDR = AW'(DATADEPTH - 1);

    logic          r_sclk_meta, r_sclk_sync, r_sclk_prev;
    logic          r_cs_meta, r_cs_sync;
    logic          r_mosi_meta, r_mosi_sync;
    logic [6:0]    r_shift;
    logic [2:0]    r_bit_cnt;
    logic          r_frame_err;

    state_t        r_state, w_state_next;
    logic          r_wr_en;
    logic          r_wr_bank;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_wr_data;
    logic [1:0]    r_full, w_full_next;
    logic          r_ready, r_rd_bank, r_overflow;

    logic          w_sclk_rise, w_byte_valid, w_accept, w_drop;
    logic          w_last_write, w_release;
    logic [7:0]    w_byte;

    assign w_sclk_rise  = r_sclk_sync & ~r_sclk_prev;
    assign w_byte_valid = w_sclk_rise & ~r_cs_sync & (r_bit_cnt == 3'd7);
    assign w_byte       = {r_shift, r_mosi_sync};

    // Serial front end: synchronisers, bit counter and shift register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sclk_meta <= 1'b0;
            r_sclk_sync <= 1'b0;
            r_sclk_prev <= 1'b0;
            r_cs_meta   <= 1'b1;
            r_cs_sync   <= 1'b1;
            r_mosi_meta <= 1'b0;
            r_mosi_sync <= 1'b0;
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_frame_err <= 1'b0;
        end else begin
            r_sclk_meta <= spi_sclk;
            r_sclk_sync <= r_sclk_meta;
            r_sclk_prev <= r_sclk_sync;
            r_cs_meta   <= spi_cs_n;
            r_cs_sync   <= r_cs_meta;
            r_mosi_meta <= spi_mosi;
            r_mosi_sync <= r_mosi_meta;
            r_frame_err <= 1'b0;
            if (r_cs_sync) begin
                r_bit_cnt   <= '0;
                r_frame_err <= (r_bit_cnt != 3'd0);
            end else if (w_sclk_rise) begin
                r_shift   <= {r_shift[5:0], r_mosi_sync};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end
        end
    end

    // The write is committed in the wr_en cycle, so the bank flips after it
    assign w_last_write = r_wr_en && (r_wr_addr == c_LAST_ADDR);
    assign w_release    = finish && r_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_drop       = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_accept = w_byte_valid;
                if (w_last_write && r_full[~r_wr_bank]) begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_WAIT: begin
                w_drop = w_byte_valid;
                if (!r_full[r_wr_bank]) begin
                    w_state_next = ST_FILL;
                end
            end
            default: w_state_next = ST_FILL;
        endcase
    end

    // Fill completion and DSP release never target the same bank
    always_comb begin
        w_full_next = r_full;
        if (w_last_write) begin
            w_full_next[r_wr_bank] = 1'b1;
        end
        if (w_release) begin
            w_full_next[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wr_en    <= 1'b0;
            r_wr_bank  <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_full     <= '0;
            r_ready    <= 1'b0;
            r_rd_bank  <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_wr_en <= w_accept;
            r_full  <= w_full_next;
            if (w_accept) begin
                r_wr_data <= w_byte;
            end
            if (r_wr_en) begin
                r_wr_addr <= r_wr_addr + AW'(1);
                if (w_last_write) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            // Forced low for a cycle after release so the DSP address resets
            if (w_release) begin
                r_rd_bank <= ~r_rd_bank;
                r_ready   <= 1'b0;
            end else begin
                r_ready   <= r_full[r_rd_bank];
            end
        end
    end

    assign wr_en     = r_wr_en;
    assign wr_bank   = r_wr_bank;
    assign wr_addr   = r_wr_addr;
    assign wr_data   = r_wr_data;
    assign ready     = r_ready;
    assign rd_bank   = r_rd_bank;
    assign overflow  = r_overflow;
    assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_spi_rx_pingpong_writer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_rx_pingpong_writer
// Brief    : Self-checking bench: SPI byte stimulus with a write scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_rx_pingpong_writer;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       spi_sclk, spi_cs_n, spi_mosi, finish;
    logic       wr_en, wr_bank, ready, rd_bank, overflow, frame_err;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    typedef struct packed {
        logic       bank;
        logic [6:0] addr;
        logic [7:0] data;
    } wr_t;

    typedef struct {
        logic [7:0] data;
        logic       exp_bank;
        logic [6:0] exp_addr;
    } vec_t;

    wr_t  sb[$];
    wr_t  mon_e;
    vec_t vecs[4];
    int   total = 0;
    int   bad   = 0;
    int   fe_cnt = 0;
    int   fe_base;
    logic fe_prev = 1'b0;

    spi_rx_pingpong_writer #(.DATADEPTH(128), .AW(7)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .spi_sclk (spi_sclk),
        .spi_cs_n (spi_cs_n),
        .spi_mosi (spi_mosi),
        .wr_en    (wr_en),
        .wr_bank  (wr_bank),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .ready    (ready),
        .rd_bank  (rd_bank),
        .finish   (finish),
        .overflow (overflow),
        .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // Scoreboard: every RAM write must match the oldest expected write
    always @(negedge clk) begin
        if (wr_en) begin
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_wr actual bank=%0d addr=%0d data=%02h required no write",
                         wr_bank, wr_addr, wr_data);
            end else begin
                mon_e = sb.pop_front();
                if ({wr_bank, wr_addr, wr_data} !== mon_e) begin
                    bad++;
                    $display("FAIL wr_stream actual bank=%0d addr=%0d data=%02h required bank=%0d addr=%0d data=%02h",
                             wr_bank, wr_addr, wr_data, mon_e.bank, mon_e.addr, mon_e.data);
                end
            end
        end
        if (frame_err) fe_cnt++;
        if (frame_err && fe_prev) begin
            total++;
            bad++;
            $display("FAIL frame_err_width actual 2+ cycles required 1");
        end
        fe_prev = frame_err;
    end

    initial begin
        #3ms;
        $display("FAIL watchdog actual timeout required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic push(input logic bank, input logic [6:0] addr, input logic [7:0] data);
        wr_t e;
        e.bank = bank;
        e.addr = addr;
        e.data = data;
        sb.push_back(e);
    endtask

    task automatic send_bit(input logic b);
        spi_mosi = b;
        #40;
        spi_sclk = 1'b1;
        #40;
        spi_sclk = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        chk("drain", sb.size(), 0);
    endtask

    task automatic pulse_finish();
        @(negedge clk);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
    endtask

    task automatic check_reset();
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_bank", wr_bank, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_ready", ready, 0);
        chk("rst_rd_bank", rd_bank, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_err", frame_err, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
    endtask

    initial begin
        vecs[0] = '{8'h3C, 1'b0, 7'd0};
        vecs[1] = '{8'hFF, 1'b0, 7'd1};
        vecs[2] = '{8'h00, 1'b0, 7'd2};
        vecs[3] = '{8'h81, 1'b0, 7'd3};

        rst_n = 1'b0; spi_sclk = 1'b0; spi_cs_n = 1'b1; spi_mosi = 1'b0; finish = 1'b0;
        repeat (3) @(negedge clk);
        check_reset();
        rst_n = 1'b1;
        spi_cs_n = 1'b0;
        #100;

        // One frame into bank 0
        for (int i = 0; i < 128; i++) begin
            push(1'b0, 7'(i), 8'(i));
            send_byte(8'(i));
        end
        drain();
        repeat (3) @(negedge clk);
        chk("b0_ready", ready, 1);
        chk("b0_rd_bank", rd_bank, 0);
        chk("b0_wr_bank", wr_bank, 1);

        // Release bank 0; bank 1 not yet full
        pulse_finish();
        chk("rel_ready_low", ready, 0);
        chk("rel_rd_bank", rd_bank, 1);
        @(negedge clk);
        chk("rel_ready_stays_low", ready, 0);
        pulse_finish();
        chk("idle_finish_rd_bank", rd_bank, 1);
        chk("idle_finish_ready", ready, 0);
        for (int i = 0; i < 128; i++) begin
            push(1'b1, 7'(i), 8'(i ^ 8'h55));
            send_byte(8'(i ^ 8'h55));
        end
        drain();
        repeat (3) @(negedge clk);
        chk("b1_ready", ready, 1);
        chk("b1_rd_bank", rd_bank, 1);
        chk("b1_wr_bank", wr_bank, 0);

        // Overflow: both banks full, extra bytes dropped
        do_reset();
        for (int i = 0; i < 256; i++) begin
            push(1'(i / 128), 7'(i % 128), 8'(255 - i));
            send_byte(8'(255 - i));
        end
        drain();
        repeat (3) @(negedge clk);
        chk("ovf_ready", ready, 1);
        chk("ovf_rd_bank", rd_bank, 0);
        for (int i = 0; i < 3; i++) send_byte(8'hEE);
        repeat (10) @(negedge clk);
        chk("ovf_flag", overflow, 1);
        chk("ovf_wait_bank", wr_bank, 0);
        pulse_finish();
        chk("ovf_rel_ready_low", ready, 0);
        chk("ovf_rel_rd_bank", rd_bank, 1);
        @(negedge clk);
        chk("ovf_ready_reassert", ready, 1);
        for (int i = 0; i < 4; i++) begin
            push(vecs[i].exp_bank, vecs[i].exp_addr, vecs[i].data);
            send_byte(vecs[i].data);
        end
        drain();
        chk("ovf_sticky", overflow, 1);

        // Frame error: chip select raised after 5 bits
        fe_base = fe_cnt;
        for (int i = 0; i < 5; i++) send_bit(1'b1);
        #40;
        spi_cs_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("frame_err_pulses", fe_cnt - fe_base, 1);
        spi_cs_n = 1'b0;
        #100;
        push(1'b0, 7'd4, 8'hA5);
        send_byte(8'hA5);
        drain();

        // Reset mid-frame after 60 bytes
        for (int i = 0; i < 60; i++) begin
            push(1'b0, 7'(5 + i), 8'(i + 16));
            send_byte(8'(i + 16));
        end
        drain();
        do_reset();
        #100;
        push(1'b0, 7'd0, 8'h5A);
        send_byte(8'h5A);
        drain();
        repeat (3) @(negedge clk);
        chk("post_rst_ready", ready, 0);
        chk("post_rst_wr_bank", wr_bank, 0);
        chk("post_rst_overflow", overflow, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
